// File: rtl/fetch_pc_generator_pkg.sv
// Shared constants and state encoding for the fetch PC generator.
package fetch_pc_generator_pkg;

  localparam logic [31:0] RESET_VADDR = 32'hBFC0_0000;
  localparam int          INST_NUM    = 4;
  localparam int          FOUR_WORDS  = 32 * INST_NUM;

  typedef enum logic {
    NORMAL   = 1'b0,
    DS_FETCH = 1'b1
  } pcg_state_e;

endpackage

// File: rtl/fetch_pc_generator_if.sv
// Fetch-group bus between the PC generator, the BTB, the instruction queue and the back end.
interface fetch_pc_generator_if;
  import fetch_pc_generator_pkg::*;

  logic                  IQ_ready_i;
  logic                  FU_redirect_i;
  logic [31:0]           FU_redirectVAddr_i;
  logic [31:0]           BTB_validDest_i;
  logic                  BTB_validTake_i;
  logic                  BTB_needDelaySlot_i;
  logic [31:0]           BTB_fifthVAddr_i;
  logic [FOUR_WORDS-1:0] PCG_VAddr_p_o;
  logic [INST_NUM-1:0]   PCG_instEnable_o;
  logic                  PCG_needDelaySlot_o;
  logic                  PCG_valid_o;

  modport master (
    input  IQ_ready_i, FU_redirect_i, FU_redirectVAddr_i,
    input  BTB_validDest_i, BTB_validTake_i, BTB_needDelaySlot_i, BTB_fifthVAddr_i,
    output PCG_VAddr_p_o, PCG_instEnable_o, PCG_needDelaySlot_o, PCG_valid_o
  );

  modport slave (
    output IQ_ready_i, FU_redirect_i, FU_redirectVAddr_i,
    output BTB_validDest_i, BTB_validTake_i, BTB_needDelaySlot_i, BTB_fifthVAddr_i,
    input  PCG_VAddr_p_o, PCG_instEnable_o, PCG_needDelaySlot_o, PCG_valid_o
  );

endinterface

// File: rtl/fetch_pc_generator_group_builder.sv
// Expands the fetch PC and state into four slot addresses, a slot-enable mask and the
// delay-slot flag. Purely combinational; the parent owns every register.
module pcg_group_builder
  import fetch_pc_generator_pkg::*;
(
  input  logic [31:0]           pc_i,
  input  pcg_state_e            state_i,
  output logic [FOUR_WORDS-1:0] vaddr_o,
  output logic [INST_NUM-1:0]   enable_o,
  output logic                  need_delay_slot_o
);

  always_comb begin
    vaddr_o           = '0;
    enable_o          = '0;
    need_delay_slot_o = 1'b0;
    // pc[1:0] passes through untouched so misalignment is still visible downstream
    for (int k = 0; k < INST_NUM; k++) begin
      vaddr_o[32*k +: 32] = {pc_i[31:4], 2'(k), pc_i[1:0]};
      enable_o[k]         = (2'(k) >= pc_i[3:2]);
    end
    if (state_i == DS_FETCH) begin
      enable_o          = {{(INST_NUM-1){1'b0}}, 1'b1};
      need_delay_slot_o = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_pc_generator.sv
// Fetch PC register and next-PC selection: back-end redirect, BTB prediction,
// sequential fetch, and a one-group detour to fetch a delay slot in the next group.
module fetch_pc_generator
  import fetch_pc_generator_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  fetch_pc_generator_if.master  pcg_if
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] saved_target_q, saved_target_d;
  pcg_state_e  state_q, state_d;
  logic        valid_q, valid_d;
  logic        accept;

  always_comb begin
    accept         = valid_q && pcg_if.IQ_ready_i;
    pc_d           = pc_q;
    saved_target_d = saved_target_q;
    state_d        = state_q;
    valid_d        = 1'b1;
    if (pcg_if.FU_redirect_i) begin
      pc_d    = pcg_if.FU_redirectVAddr_i;
      state_d = NORMAL;
    end else if (accept) begin
      unique case (state_q)
        NORMAL: begin
          if (pcg_if.BTB_validTake_i && pcg_if.BTB_needDelaySlot_i) begin
            // Fetch the delay slot first; the branch target waits in saved_target
            pc_d           = pcg_if.BTB_fifthVAddr_i;
            saved_target_d = pcg_if.BTB_validDest_i;
            state_d        = DS_FETCH;
          end else if (pcg_if.BTB_validTake_i) begin
            pc_d = pcg_if.BTB_validDest_i;
          end else begin
            pc_d = pcg_if.BTB_fifthVAddr_i;
          end
        end
        DS_FETCH: begin
          pc_d    = saved_target_q;
          state_d = NORMAL;
        end
        default: state_d = NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q           <= RESET_VADDR;
      saved_target_q <= '0;
      state_q        <= NORMAL;
      valid_q        <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      saved_target_q <= saved_target_d;
      state_q        <= state_d;
      valid_q        <= valid_d;
    end
  end

  pcg_group_builder u_group_builder (
    .pc_i              (pc_q),
    .state_i           (state_q),
    .vaddr_o           (pcg_if.PCG_VAddr_p_o),
    .enable_o          (pcg_if.PCG_instEnable_o),
    .need_delay_slot_o (pcg_if.PCG_needDelaySlot_o)
  );

  assign pcg_if.PCG_valid_o = valid_q;

endmodule
